// File: rtl/wave_pkg.sv
// Shared encodings and width helpers for the wave_osc_p oscillator core.
package wave_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_SQUARE = 2'b10,
    WAVE_TRI    = 2'b11
  } wave_mode_e;

  function automatic int frac_w(input int phase_w, input int lut_aw);
    return phase_w - 2 - lut_aw;
  endfunction

  function automatic int sum_w(input int lut_dw, input int fw);
    return lut_dw + fw + 1;
  endfunction

  function automatic longint full_scale(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/quarter_wave_lut.sv
// Registered quarter-sine ROM with NPORT independent read ports.
module quarter_wave_lut #(
  parameter int LUT_AW = 9,
  parameter int LUT_DW = 16,
  parameter int NPORT  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NPORT-1:0][LUT_AW-1:0]  addr,
  output logic [NPORT-1:0][LUT_DW-1:0]  data
);
  localparam int DEPTH = 1 << LUT_AW;

  // Contents are elaborated from a Taylor series so no external init file is needed.
  function automatic int sin_entry(input int k);
    real x, term, s;
    x    = 3.14159265358979323846 / 2.0 * $itor(k) / $itor(DEPTH);
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / $itor((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return $rtoi(s * $itor((1 << (LUT_DW - 1)) - 1) + 0.5);
  endfunction

  logic [LUT_DW-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = LUT_DW'(sin_entry(k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      for (int p = 0; p < NPORT; p++) data[p] <= rom[addr[p]];
    end
  end

endmodule

// File: rtl/wave_osc_p.sv
// 4-stage sine/saw/square/triangle oscillator; WAVE_INTERP_EN enables two-point sine interpolation.
module wave_osc_p
  import wave_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 9,
  parameter int LUT_DW  = 16,
  parameter int OUT_W   = 24,
  parameter int TAG_W   = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     wav_en,
  input  logic [1:0]               i_mode,
  input  logic [PHASE_W-1:0]       i_phase,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic                     i_valid,
  output logic signed [OUT_W-1:0]  o_wave,
  output logic [TAG_W-1:0]         o_tag,
  output logic                     o_valid
);
  localparam int FRAC_W = frac_w(PHASE_W, LUT_AW);
  localparam int SUM_W  = sum_w(LUT_DW, FRAC_W);
  localparam int PA_W   = LUT_AW + 2;
  localparam int STAGES = 4;
`ifdef WAVE_INTERP_EN
  localparam int NPT = 2;
`else
  localparam int NPT = 1;
`endif
  localparam logic [OUT_W-1:0] FS  = OUT_W'(full_scale(OUT_W));
  localparam logic [OUT_W-1:0] MSB = {1'b1, {(OUT_W-1){1'b0}}};

  logic adv;
  assign adv = clk_en & wav_en;

  logic [STAGES:1]                vld_pipe;
  logic [STAGES-1:1][1:0]         mode_pipe;
  logic [STAGES-1:1][TAG_W-1:0]   tag_pipe;
  logic [STAGES-1:1][OUT_W-1:0]   x_pipe;

  logic [NPT-1:0][PA_W-1:0]       pt;
  logic [NPT-1:0][LUT_AW-1:0]     addr_c, addr_s1;
  logic [NPT-1:0]                 neg_c, neg_s1, neg_s2;
  logic [NPT-1:0][LUT_DW-1:0]     rd, pts_s3;
`ifdef WAVE_INTERP_EN
  logic [FRAC_W-1:0]              frac_s1, frac_s2;
  logic [NPT-1:0][FRAC_W:0]       wts_s3;
`endif

  // Point B is A+1 and wraps across the period, so each point gets its own mirror/negate.
  for (genvar p = 0; p < NPT; p++) begin : g_pt
    assign pt[p]     = i_phase[PHASE_W-1 -: PA_W] + PA_W'(p);
    assign neg_c[p]  = pt[p][PA_W-1];
    assign addr_c[p] = pt[p][PA_W-2] ? ~pt[p][LUT_AW-1:0] : pt[p][LUT_AW-1:0];
  end

  quarter_wave_lut #(.LUT_AW(LUT_AW), .LUT_DW(LUT_DW), .NPORT(NPT)) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .addr  (addr_s1),
    .data  (rd)
  );

  logic signed [SUM_W-1:0] sum;
  logic [OUT_W-1:0]        x4, tri_y, wave_c;

  always_comb begin
    sum = '0;
`ifdef WAVE_INTERP_EN
    for (int p = 0; p < NPT; p++)
      sum = sum + SUM_W'($signed(pts_s3[p])) * SUM_W'($signed({1'b0, wts_s3[p]}));
`else
    sum = SUM_W'($signed(pts_s3[0])) <<< FRAC_W;
`endif
    x4     = x_pipe[STAGES-1];
    tri_y  = x4[OUT_W-1] ? ~(x4 << 1) : (x4 << 1);
    wave_c = '0;
    unique case (wave_mode_e'(mode_pipe[STAGES-1]))
      WAVE_SINE:   wave_c = OUT_W'(sum >>> (SUM_W - OUT_W));
      WAVE_SAW:    wave_c = x4 ^ MSB;
      WAVE_SQUARE: wave_c = x4[OUT_W-1] ? -FS : FS;
      WAVE_TRI:    wave_c = tri_y ^ MSB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      mode_pipe <= '0;
      tag_pipe  <= '0;
      x_pipe    <= '0;
      addr_s1   <= '0;
      neg_s1    <= '0;
      neg_s2    <= '0;
      pts_s3    <= '0;
`ifdef WAVE_INTERP_EN
      frac_s1   <= '0;
      frac_s2   <= '0;
      wts_s3    <= '0;
`endif
      o_wave    <= '0;
      o_tag     <= '0;
    end else if (!wav_en) begin
      vld_pipe <= '0;
      o_wave   <= '0;
      o_tag    <= '0;
    end else if (clk_en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], i_valid};
      mode_pipe <= {mode_pipe[STAGES-2:1], i_mode};
      tag_pipe  <= {tag_pipe[STAGES-2:1], i_tag};
      x_pipe    <= {x_pipe[STAGES-2:1], i_phase[PHASE_W-1 -: OUT_W]};
      addr_s1   <= addr_c;
      neg_s1    <= neg_c;
      neg_s2    <= neg_s1;
      for (int p = 0; p < NPT; p++) pts_s3[p] <= neg_s2[p] ? -rd[p] : rd[p];
`ifdef WAVE_INTERP_EN
      frac_s1   <= i_phase[FRAC_W-1:0];
      frac_s2   <= frac_s1;
      wts_s3[0] <= {1'b1, {FRAC_W{1'b0}}} - {1'b0, frac_s2};
      wts_s3[1] <= {1'b0, frac_s2};
`endif
      o_wave    <= vld_pipe[STAGES-1] ? wave_c : '0;
      o_tag     <= vld_pipe[STAGES-1] ? tag_pipe[STAGES-1] : '0;
    end
  end

  assign o_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_wave_osc_p.sv
// Randomised + directed bench for wave_osc_p against an arithmetic scoreboard model.
module tb_wave_osc_p;
  logic        clk = 1'b0;
  logic        rst_n, clk_en, wav_en, i_valid;
  logic [1:0]  i_mode;
  logic [23:0] i_phase;
  logic [6:0]  i_tag;
  logic signed [23:0] o_wave;
  logic [6:0]  o_tag;
  logic        o_valid;

  wave_osc_p dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wav_en(wav_en),
    .i_mode(i_mode), .i_phase(i_phase), .i_tag(i_tag), .i_valid(i_valid),
    .o_wave(o_wave), .o_tag(o_tag), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  tag;
    logic [23:0] wave;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          lut[512];
  int          total = 0, bad = 0, en_cnt = 0;
  logic        ev = 1'b0;
  logic [23:0] ew = '0;
  logic [6:0]  et = '0;
  logic [23:0] lit = '0;
  bit          use_lit = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Quarter-wave point with mirror and negate, from quadrant arithmetic.
  function automatic longint pt_val(input longint p);
    longint q, i, v;
    q = (p / 512) % 4;
    i = p % 512;
    v = lut[(q % 2 == 1) ? 511 - i : i];
    return (q >= 2) ? -v : v;
  endfunction

  function automatic logic [23:0] model(input logic [1:0] m, input logic [23:0] ph);
    longint x, r, pa, fr;
    x = longint'(ph);
    r = 0;
    case (m)
      2'd0: begin
        pa = x / 8192;
        fr = x % 8192;
`ifdef WAVE_INTERP_EN
        r = (pt_val(pa) * (8192 - fr) + pt_val((pa + 1) % 2048) * fr) >>> 6;
`else
        r = pt_val(pa) * 128;
`endif
      end
      2'd1: r = x - (longint'(1) << 23);
      2'd2: r = (x >= (longint'(1) << 23)) ? -((longint'(1) << 23) - 1) : (longint'(1) << 23) - 1;
      default: r = (x < (longint'(1) << 23)) ? 2 * x - (longint'(1) << 23)
                                              : (longint'(1) << 23) - 1 - 2 * (x - (longint'(1) << 23));
    endcase
    return r[23:0];
  endfunction

  task automatic set_lit(input longint v);
    lit     = v[23:0];
    use_lit = 1'b1;
  endtask

  task automatic step(input logic v, input logic [1:0] m, input logic [23:0] ph,
                      input logic [6:0] tg, input logic ce, input logic we);
    exp_t e;
    i_valid = v; i_mode = m; i_phase = ph; i_tag = tg; clk_en = ce; wav_en = we;
    @(posedge clk);
    #1;
    if (!we) begin
      sb.delete();
      ev = 1'b0; ew = '0; et = '0;
    end else if (ce) begin
      if (v) begin
        e.tag  = tg;
        e.wave = use_lit ? lit : model(m, ph);
        e.due  = en_cnt + 4;
        sb.push_back(e);
      end
      en_cnt++;
      if (sb.size() > 0 && sb[0].due == en_cnt) begin
        ev = 1'b1; ew = sb[0].wave; et = sb[0].tag;
        void'(sb.pop_front());
      end else begin
        ev = 1'b0; ew = '0; et = '0;
      end
    end
    use_lit = 1'b0;
    chk("valid", {63'b0, o_valid}, {63'b0, ev});
    chk("wave", {40'b0, o_wave}, {40'b0, ew});
    if (ev) chk("tag", {57'b0, o_tag}, {57'b0, et});
  endtask

  initial begin
    logic [1:0]  m;
    logic [23:0] ph;
    logic        ce;
    int          n;
    for (int k = 0; k < 512; k++)
      lut[k] = $rtoi(32767.0 * $sin(3.14159265358979323846 / 2.0 * $itor(k) / 512.0) + 0.5);

    rst_n = 1'b0; clk_en = 1'b0; wav_en = 1'b0; i_valid = 1'b0;
    i_mode = '0; i_phase = '0; i_tag = '0;
    #12;
    chk("rst_valid", {63'b0, o_valid}, 64'd0);
    chk("rst_wave", {40'b0, o_wave}, 64'd0);
    chk("rst_tag", {57'b0, o_tag}, 64'd0);
    rst_n = 1'b1;

    // Directed sine points, wrap, and fixed-value non-sine corners.
    set_lit(longint'(lut[0]) << 7);         step(1, 2'd0, 24'h000000, 7'd1, 1, 1);
    set_lit(longint'(lut[511]) << 7);       step(1, 2'd0, 24'h400000, 7'd2, 1, 1);
    set_lit(-(longint'(lut[511]) << 7));    step(1, 2'd0, 24'hC00000, 7'd3, 1, 1);
`ifdef WAVE_INTERP_EN
    set_lit(longint'(lut[0] + lut[1]) << 6);
`else
    set_lit(longint'(lut[0]) << 7);
`endif
    step(1, 2'd0, 24'h001000, 7'd4, 1, 1);
    step(1, 2'd0, 24'hFFFFFF, 7'd5, 1, 1);
    set_lit(24'h800000); step(1, 2'd1, 24'h000000, 7'd6, 1, 1);
    set_lit(24'h7FFFFF); step(1, 2'd1, 24'hFFFFFF, 7'd7, 1, 1);
    set_lit(24'h7FFFFF); step(1, 2'd2, 24'h000001, 7'd8, 1, 1);
    set_lit(24'h800001); step(1, 2'd2, 24'h800000, 7'd9, 1, 1);
    set_lit(24'h800000); step(1, 2'd3, 24'h000000, 7'd10, 1, 1);
    set_lit(24'h7FFFFF); step(1, 2'd3, 24'h800000, 7'd11, 1, 1);
    for (int k = 0; k < 6; k++) step(0, 2'd0, 24'h0, 7'd0, 1, 1);

    // 20 back-to-back valids under random clk_en; upstream holds its word while frozen.
    n = 0; m = 2'($urandom_range(3)); ph = 24'($urandom);
    while (n < 20) begin
      ce = ($urandom_range(2) != 0);
      step(1, m, ph, 7'(n), ce, 1);
      if (ce) begin
        n++; m = 2'($urandom_range(3)); ph = 24'($urandom);
      end
    end
    for (int k = 0; k < 12; k++) step(0, 2'd0, 24'h0, 7'd0, 1'($urandom_range(1)), 1);
    chk("burst_drained", 64'(sb.size()), 64'd0);

    // Flush mid-burst drops everything in flight.
    for (int k = 0; k < 5; k++) step(1, 2'd1, 24'($urandom), 7'(40 + k), 1, 1);
    step(1, 2'd1, 24'h123456, 7'd50, 1, 0);
    chk("flush_tag", {57'b0, o_tag}, 64'd0);
    for (int k = 0; k < 6; k++) step(1, 2'($urandom_range(3)), 24'($urandom), 7'(60 + k), 1, 1);
    for (int k = 0; k < 6; k++) step(0, 2'd0, 24'h0, 7'd0, 1, 1);

    // Async reset mid-burst: outputs clear without a clock edge.
    for (int k = 0; k < 6; k++) step(1, 2'd1, 24'h100000 + 24'(k), 7'(70 + k), 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'b0, o_valid}, 64'd0);
    chk("arst_wave", {40'b0, o_wave}, 64'd0);
    chk("arst_tag", {57'b0, o_tag}, 64'd0);
    sb.delete(); ev = 1'b0; ew = '0; et = '0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1, 2'($urandom_range(3)), 24'($urandom), 7'(80 + k), 1, 1);
    for (int k = 0; k < 6; k++) step(0, 2'd0, 24'h0, 7'd0, 1, 1);

    // Random mix of bubbles, freezes and occasional flushes.
    for (int k = 0; k < 200; k++)
      step(1'($urandom_range(3) != 0), 2'($urandom_range(3)), 24'($urandom), 7'($urandom),
           1'($urandom_range(4) != 0), 1'($urandom_range(24) != 0));
    for (int k = 0; k < 8; k++) step(0, 2'd0, 24'h0, 7'd0, 1, 1);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
